id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core.
- Captures the decode-stage control bundle (control unit outputs) and the decode-stage datapath operands, and presents them to EX.
- Contains load-use hazard detection, bubble insertion, flush and hold logic.
- EX-stage ALU, mux selects and the write-back path consume its outputs.

---
 rtl/id_ex_stage_reg.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use detection, bubble, flush and hold.
// Optional event counters are enabled with the ID_EX_EVENT_CNT_EN macro.
module id_ex_stage_reg #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_d,
   input  logic            reg_write_d,
   input  logic [1:0]      result_src_d,
   input  logic            mem_write_d,
   input  logic            jump_d,
   input  logic            branch_d,
   input  logic            alu_src_d,
   input  logic [1:0]      alu_op_d,
   input  logic            alu_src_a_d,
   input  logic [2:0]      funct3_d,
   input  logic            funct7b5_d,
   input  logic [XLEN-1:0] rd1_d,
   input  logic [XLEN-1:0] rd2_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pc_plus4_d,
   input  logic [XLEN-1:0] imm_ext_d,
   input  logic [RA_W-1:0] rs1_d,
   input  logic [RA_W-1:0] rs2_d,
   input  logic [RA_W-1:0] rd_d,
   input  logic            flush_e,
   input  logic            stall_e,
   output logic            lw_stall,
`ifdef ID_EX_EVENT_CNT_EN
   output logic [CNT_W-1:0] bubble_cnt_e,
   output logic [CNT_W-1:0] flush_cnt_e,
`endif
   output logic            valid_e,
   output logic            reg_write_e,
   output logic [1:0]      result_src_e,
   output logic            mem_write_e,
   output logic            jump_e,
   output logic            branch_e,
   output logic            alu_src_e,
   output logic [1:0]      alu_op_e,
   output logic            alu_src_a_e,
   output logic [2:0]      funct3_e,
   output logic            funct7b5_e,
   output logic [XLEN-1:0] rd1_e,
   output logic [XLEN-1:0] rd2_e,
   output logic [XLEN-1:0] pc_e,
   output logic [XLEN-1:0] pc_plus4_e,
   output logic [XLEN-1:0] imm_ext_e,
   output logic [RA_W-1:0] rs1_e,
   output logic [RA_W-1:0] rs2_e,
   output logic [RA_W-1:0] rd_e
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic [1:0]      result_src;
      logic            mem_write;
      logic            jump;
      logic            branch;
      logic            alu_src;
      logic [1:0]      alu_op;
      logic            alu_src_a;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] imm_ext;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [RA_W-1:0] rd;
   } ex_slot_t;

   ex_slot_t ex_q, ex_d, in_s, bub_s;

   // Conservative: rs2 is compared even for formats that do not read it.
   assign lw_stall = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.rd != '0) &&
                     valid_d && ((rs1_d == ex_q.rd) || (rs2_d == ex_q.rd));

   always_comb begin
      in_s.valid      = valid_d;
      in_s.reg_write  = reg_write_d;
      in_s.result_src = result_src_d;
      in_s.mem_write  = mem_write_d;
      in_s.jump       = jump_d;
      in_s.branch     = branch_d;
      in_s.alu_src    = alu_src_d;
      in_s.alu_op     = alu_op_d;
      in_s.alu_src_a  = alu_src_a_d;
      in_s.funct3     = funct3_d;
      in_s.funct7b5   = funct7b5_d;
      in_s.rd1        = rd1_d;
      in_s.rd2        = rd2_d;
      in_s.pc         = pc_d;
      in_s.pc_plus4   = pc_plus4_d;
      in_s.imm_ext    = imm_ext_d;
      in_s.rs1        = rs1_d;
      in_s.rs2        = rs2_d;
      in_s.rd         = rd_d;

      // Bubble kills control and rd but still loads data so EX sees defined values.
      bub_s            = in_s;
      bub_s.valid      = 1'b0;
      bub_s.reg_write  = 1'b0;
      bub_s.result_src = 2'b00;
      bub_s.mem_write  = 1'b0;
      bub_s.jump       = 1'b0;
      bub_s.branch     = 1'b0;
      bub_s.alu_src    = 1'b0;
      bub_s.alu_op     = 2'b00;
      bub_s.alu_src_a  = 1'b0;
      bub_s.rd         = '0;

      ex_d = in_s;
      if (flush_e)                  ex_d = bub_s;
      else if (stall_e)             ex_d = ex_q;
      else if (lw_stall || !valid_d) ex_d = bub_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

`ifdef ID_EX_EVENT_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         if (flush_e) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         if (!flush_e && !stall_e && lw_stall) bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
      end
   end

   assign bubble_cnt_e = bubble_cnt_q;
   assign flush_cnt_e  = flush_cnt_q;
`endif

   assign valid_e      = ex_q.valid;
   assign reg_write_e  = ex_q.reg_write;
   assign result_src_e = ex_q.result_src;
   assign mem_write_e  = ex_q.mem_write;
   assign jump_e       = ex_q.jump;
   assign branch_e     = ex_q.branch;
   assign alu_src_e    = ex_q.alu_src;
   assign alu_op_e     = ex_q.alu_op;
   assign alu_src_a_e  = ex_q.alu_src_a;
   assign funct3_e     = ex_q.funct3;
   assign funct7b5_e   = ex_q.funct7b5;
   assign rd1_e        = ex_q.rd1;
   assign rd2_e        = ex_q.rd2;
   assign pc_e         = ex_q.pc;
   assign pc_plus4_e   = ex_q.pc_plus4;
   assign imm_ext_e    = ex_q.imm_ext;
   assign rs1_e        = ex_q.rs1;
   assign rs2_e        = ex_q.rs2;
   assign rd_e         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard/priority cases plus random traffic
// checked every cycle against a rule-level model of the ID/EX slot.
module tb_id_ex_stage_reg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;
`ifdef ID_EX_EVENT_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 32;
`endif

   logic clk = 0, rst_n = 0;
   logic valid_d = 0, reg_write_d = 0, mem_write_d = 0, jump_d = 0, branch_d = 0;
   logic alu_src_d = 0, alu_src_a_d = 0, funct7b5_d = 0, flush_e = 0, stall_e = 0;
   logic [1:0] result_src_d = 0, alu_op_d = 0;
   logic [2:0] funct3_d = 0;
   logic [XLEN-1:0] rd1_d = 0, rd2_d = 0, pc_d = 0, pc_plus4_d = 0, imm_ext_d = 0;
   logic [RA_W-1:0] rs1_d = 0, rs2_d = 0, rd_d = 0;

   logic lw_stall, valid_e, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_src_a_e, funct7b5_e;
   logic [1:0] result_src_e, alu_op_e;
   logic [2:0] funct3_e;
   logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
   logic [RA_W-1:0] rs1_e, rs2_e, rd_e;
`ifdef ID_EX_EVENT_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_e, flush_cnt_e;
   int m_bcnt, m_fcnt;
`endif

   int n_cmp = 0, n_bad = 0;

   id_ex_stage_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
      .result_src_d(result_src_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
      .branch_d(branch_d), .alu_src_d(alu_src_d), .alu_op_d(alu_op_d),
      .alu_src_a_d(alu_src_a_d), .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .flush_e(flush_e), .stall_e(stall_e), .lw_stall(lw_stall),
`ifdef ID_EX_EVENT_CNT_EN
      .bubble_cnt_e(bubble_cnt_e), .flush_cnt_e(flush_cnt_e),
`endif
      .valid_e(valid_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e),
      .mem_write_e(mem_write_e), .jump_e(jump_e), .branch_e(branch_e),
      .alu_src_e(alu_src_e), .alu_op_e(alu_op_e), .alu_src_a_e(alu_src_a_e),
      .funct3_e(funct3_e), .funct7b5_e(funct7b5_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
      .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .imm_ext_e(imm_ext_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
   );

   always #5 clk = ~clk;

   // Model of the EX slot: control fields and data fields held separately.
   logic m_valid, m_rw, m_mw, m_j, m_b, m_as, m_asa, m_f7;
   logic [1:0] m_rs, m_aop;
   logic [2:0] m_f3;
   logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
   logic [RA_W-1:0] m_rs1, m_rs2, m_rd;

   function automatic logic m_hazard();
      return m_valid && m_rs == 2'b01 && m_rd != 0 && valid_d && (rs1_d == m_rd || rs2_d == m_rd);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {m_valid, m_rw, m_mw, m_j, m_b, m_as, m_asa, m_f7, m_rs, m_aop, m_f3} = '0;
         {m_rd1, m_rd2, m_pc, m_pc4, m_imm, m_rs1, m_rs2, m_rd} = '0;
`ifdef ID_EX_EVENT_CNT_EN
         m_bcnt = 0; m_fcnt = 0;
`endif
      end else begin
         logic hz;
         hz = m_hazard();
`ifdef ID_EX_EVENT_CNT_EN
         if (flush_e) m_fcnt = (m_fcnt + 1) % (1 << CNT_W);
         if (!flush_e && !stall_e && hz) m_bcnt = (m_bcnt + 1) % (1 << CNT_W);
`endif
         if (flush_e || !stall_e) begin
            // data always follows decode unless held
            m_rd1 = rd1_d; m_rd2 = rd2_d; m_pc = pc_d; m_pc4 = pc_plus4_d; m_imm = imm_ext_d;
            m_rs1 = rs1_d; m_rs2 = rs2_d; m_f3 = funct3_d; m_f7 = funct7b5_d;
            if (flush_e || hz || !valid_d) begin
               {m_valid, m_rw, m_mw, m_j, m_b, m_as, m_asa, m_rs, m_aop, m_rd} = '0;
            end else begin
               m_valid = 1; m_rw = reg_write_d; m_mw = mem_write_d; m_j = jump_d; m_b = branch_d;
               m_as = alu_src_d; m_asa = alu_src_a_d; m_rs = result_src_d; m_aop = alu_op_d; m_rd = rd_d;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [255:0] dut_vec();
      return {valid_e, reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e,
              alu_op_e, alu_src_a_e, funct3_e, funct7b5_e, rd1_e, rd2_e, pc_e, pc_plus4_e,
              imm_ext_e, rs1_e, rs2_e, rd_e};
   endfunction

   always @(negedge clk) begin
      chk("slot", dut_vec(), {m_valid, m_rw, m_rs, m_mw, m_j, m_b, m_as, m_aop, m_asa, m_f3, m_f7,
                              m_rd1, m_rd2, m_pc, m_pc4, m_imm, m_rs1, m_rs2, m_rd});
      chk("lw_stall", lw_stall, m_hazard());
      chk("write_implies_valid", (reg_write_e || mem_write_e) && !valid_e, 0);
`ifdef ID_EX_EVENT_CNT_EN
      chk("bubble_cnt", bubble_cnt_e, m_bcnt);
      chk("flush_cnt", flush_cnt_e, m_fcnt);
`endif
   end

   task automatic set_dec(input logic v, input logic rw, input logic [1:0] rsrc, input logic [1:0] aop,
                          input int r1, input int r2, input int rd, input logic [XLEN-1:0] d1);
      valid_d = v; reg_write_d = rw; result_src_d = rsrc; alu_op_d = aop;
      rs1_d = RA_W'(r1); rs2_d = RA_W'(r2); rd_d = RA_W'(rd); rd1_d = d1;
      mem_write_d = 0; jump_d = 0; branch_d = 0; alu_src_d = 0; alu_src_a_d = 0;
   endtask

   task automatic edge1();
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("reset_valid", valid_e, 0);
      chk("reset_rd", rd_e, 0);
      chk("reset_lw", lw_stall, 0);
      set_dec(1, 1, 2'b00, 2'b10, 1, 2, 5, 32'h12345678);
      edge1();
      chk("load_valid", valid_e, 1);
      chk("load_rd1", rd1_e, 32'h12345678);
      chk("load_rd", rd_e, 5);
      chk("load_aop", alu_op_e, 2'b10);
      set_dec(1, 1, 2'b01, 2'b00, 1, 2, 7, 32'h0);      // lw x7
      edge1();
      set_dec(1, 1, 2'b00, 2'b10, 3, 7, 9, 32'hA5A5);   // consumer of x7 via rs2
      #1 chk("lu_detect", lw_stall, 1);
      edge1();
      chk("lu_bubble_valid", valid_e, 0);
      chk("lu_bubble_rw", reg_write_e, 0);
      chk("lu_bubble_rd", rd_e, 0);
      chk("lu_drop", lw_stall, 0);
      edge1();
      chk("lu_consumer_valid", valid_e, 1);
      chk("lu_consumer_rd", rd_e, 9);
      set_dec(1, 1, 2'b01, 2'b00, 0, 0, 0, 32'h0);      // load to x0
      edge1();
      set_dec(1, 1, 2'b01, 2'b00, 0, 0, 3, 32'h0);
      #1 chk("x0_no_hazard", lw_stall, 0);
      edge1();
      set_dec(1, 1, 2'b00, 2'b10, 4, 5, 6, 32'h0);
      #1 chk("nomatch_no_hazard", lw_stall, 0);
      edge1();
      set_dec(1, 1, 2'b01, 2'b00, 0, 0, 7, 32'h0);
      edge1();
      set_dec(1, 1, 2'b00, 2'b10, 7, 0, 10, 32'h0);
      flush_e = 1; stall_e = 1;
      #1 chk("prio_lw", lw_stall, 1);
      edge1();
      chk("prio_valid", valid_e, 0);
      chk("prio_rd", rd_e, 0);
      flush_e = 0; stall_e = 0;
      set_dec(1, 1, 2'b01, 2'b00, 0, 0, 4, 32'h0);
      edge1();
      set_dec(1, 1, 2'b00, 2'b10, 4, 0, 11, 32'hCAFE);
      edge1();
`ifdef ID_EX_EVENT_CNT_EN
      chk("cnt_bubble_2", bubble_cnt_e, 2);
      chk("cnt_flush_1", flush_cnt_e, 1);
`endif
      edge1();
      chk("pre_hold_rd", rd_e, 11);
      stall_e = 1;
      set_dec(1, 0, 2'b10, 2'b01, 8, 9, 12, 32'hDEAD);
      for (int i = 0; i < 3; i++) begin
         edge1();
         chk("hold_rd", rd_e, 11);
         chk("hold_rd1", rd1_e, 32'hCAFE);
      end
      stall_e = 0;
`ifdef ID_EX_EVENT_CNT_EN
      // two more bubbles take the 2-bit counter from 2 through 3 to 0
      for (int i = 0; i < 2; i++) begin
         set_dec(1, 1, 2'b01, 2'b00, 0, 0, 4, 32'h0);
         edge1();
         set_dec(1, 1, 2'b00, 2'b10, 4, 0, 11, 32'h0);
         edge1();
      end
      chk("cnt_wrap", bubble_cnt_e, 0);
`endif
      set_dec(1, 1, 2'b01, 2'b00, 1, 2, 6, 32'h77);
      edge1();
      chk("pre_reset_valid", valid_e, 1);
      stall_e = 1;
      #2 rst_n = 0;
      #1 chk("async_reset_slot", dut_vec(), 0);
      chk("async_reset_lw", lw_stall, 0);
      stall_e = 0;
      edge1();
      rst_n = 1;

      for (int c = 0; c < 3000; c++) begin
         valid_d      = ($urandom_range(7) != 0);
         reg_write_d  = $urandom_range(1);
         result_src_d = 2'($urandom_range(3));
         mem_write_d  = $urandom_range(1);
         jump_d       = $urandom_range(1);
         branch_d     = $urandom_range(1);
         alu_src_d    = $urandom_range(1);
         alu_op_d     = 2'($urandom_range(3));
         alu_src_a_d  = $urandom_range(1);
         funct3_d     = 3'($urandom_range(7));
         funct7b5_d   = $urandom_range(1);
         rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; pc_plus4_d = $urandom; imm_ext_d = $urandom;
         rs1_d = RA_W'($urandom_range(7));
         rs2_d = RA_W'($urandom_range(7));
         rd_d  = RA_W'($urandom_range(7));
         flush_e = ($urandom_range(9) == 0);
         stall_e = ($urandom_range(7) == 0);
         if (c == 1500) begin
            stall_e = 1;
            #2 rst_n = 0;
            #3 rst_n = 1;
         end
         edge1();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
